e1_wb_tx_bdmgr: RTL and testbench

Parametrised TX buffer-descriptor and control manager for the E1 wishbone core. It generalises the fixed per-port TX CSR/BD logic:
- configurable BD queue depth;
- fill-level readback;
- maskable interrupt sources, including a low-water submit interrupt;
- saturating underflow counter;
- sticky completion-overflow flag.

It sits between the wishbone bus decoder and the `e1_tx` core, driving the core's control and BD inputs.

---
 rtl/e1_wb_tx_bdmgr_pkg.sv | 32 +++
 rtl/e1_wb_tx_bdmgr_bd_fifo.sv | 72 +++++++
 rtl/e1_wb_tx_bdmgr.sv | 200 ++++++++++++++++++++
 tb/tb_e1_wb_tx_bdmgr.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/e1_wb_tx_bdmgr_pkg.sv
// Shared definitions for the E1 wishbone TX buffer-descriptor manager.
// Holds the register map indices, the CSR/IRQ bit positions and the
// framing mode encodings used by the top level and by the testbench.
package e1_wb_tx_bdmgr_pkg;

    // Register indices (bus_addr_lsb)
    localparam logic [1:0] REG_CSR = 2'd0;
    localparam logic [1:0] REG_BD  = 2'd1;
    localparam logic [1:0] REG_IRQ = 2'd2;
    localparam logic [1:0] REG_LVL = 2'd3;

    // CSR write/read bit positions
    localparam int CSR_EN       = 0;
    localparam int CSR_TSRC     = 3;
    localparam int CSR_ALARM    = 4;
    localparam int CSR_UF_CLR   = 12;
    localparam int CSR_OV_CLR   = 13;

    // IRQ enable bit positions
    localparam int IRQ_CQ_EN = 0;
    localparam int IRQ_UF_EN = 1;
    localparam int IRQ_LW_EN = 2;

    // Framing modes held in CSR[2:1]
    typedef enum logic [1:0] {
        MODE_RAW       = 2'd0,
        MODE_FRAMED    = 2'd1,
        MODE_CRC4      = 2'd2,
        MODE_CRC4_AUTO = 2'd3
    } mode_e;

endpackage

// File: rtl/e1_wb_tx_bdmgr_bd_fifo.sv
// e1_bd_fifo: small circular buffer used for the submit and completion
// BD queues.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  push strobe and data (caller must not push when full)
//   rd_en, rd_data  pop strobe (caller must not pop when empty), head data
//   full, empty     status flags
//   level           number of stored entries
module e1_bd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        level_d = level_q + LW'(wr_en) - LW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;

endmodule

// File: rtl/e1_wb_tx_bdmgr.sv
// e1_wb_tx_bdmgr: TX buffer-descriptor and control manager for the E1
// wishbone core. Decodes four bus registers (CSR, BD, IRQ, levels), keeps
// a submit queue feeding the e1_tx core and a completion queue the host
// drains, and tracks underflow/overflow events.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus_*                     register bus (select, index, data, strobes)
//   bd_mf, bd_crc_e, bd_valid head submit BD towards the core
//   bd_done, bd_miss          core consumed head BD / found no BD
//   crc_e_auto, crc_e_ack     RX-derived E bits and their acknowledge
//   ctrl_*                    core control outputs
//   irq                       interrupt request
// Handshake: bd_valid is high while the submit queue holds a BD; the core
// pulses bd_done for one cycle per consumed head BD, which pops the submit
// queue on that clock edge. A bd_done while bd_valid is low is ignored.
module e1_wb_tx_bdmgr
    import e1_wb_tx_bdmgr_pkg::*;
#(
    parameter int MFW   = 7,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           bus_addr_sel,
    input  logic [1:0]     bus_addr_lsb,
    input  logic [15:0]    bus_wdata,
    output logic [15:0]    bus_rdata,
    input  logic           bus_we,
    input  logic           bus_clr,
    output logic [MFW-1:0] bd_mf,
    output logic [1:0]     bd_crc_e,
    output logic           bd_valid,
    input  logic           bd_done,
    input  logic           bd_miss,
    input  logic [1:0]     crc_e_auto,
    output logic           crc_e_ack,
    output logic           ctrl_rst,
    output logic           ctrl_time_src,
    output logic           ctrl_do_framing,
    output logic           ctrl_do_crc4,
    output logic           ctrl_alarm,
    output logic [1:0]     ctrl_loopback,
    output logic           irq
);
    localparam int LW = $clog2(DEPTH+1);

    logic [6:0]      csr_q, csr_d;
    logic            ctrl_rst_q, ctrl_rst_d;
    logic [2:0]      irq_en_q, irq_en_d;
    logic [3:0]      thr_q, thr_d;
    logic            uf_q, uf_d;
    logic            ov_q, ov_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            wr_any, rd_any, wr_csr, wr_bd, wr_irq, rd_bd;
    logic            sq_push, sq_pop, cq_push, cq_pop, done_v;
    logic            sq_full, sq_empty, cq_full, cq_empty;
    logic [LW-1:0]   sq_level, cq_level;
    logic [MFW+1:0]  sq_head;
    logic [MFW-1:0]  cq_head;
    logic            low_water;
    mode_e           mode;
    logic            unused_bits;

    // Strobe decode; bus_clr kills every strobe of the cycle.
    assign wr_any = bus_addr_sel & bus_we & ~bus_clr;
    assign rd_any = bus_addr_sel & ~bus_we & ~bus_clr;
    assign wr_csr = wr_any & (bus_addr_lsb == REG_CSR);
    assign wr_bd  = wr_any & (bus_addr_lsb == REG_BD);
    assign wr_irq = wr_any & (bus_addr_lsb == REG_IRQ);
    assign rd_bd  = rd_any & (bus_addr_lsb == REG_BD);

    // Queue strobes are masked by the flags of the current state, so a
    // push into a full queue or a pop of an empty one never reaches a FIFO.
    assign done_v  = bd_done & ~sq_empty;
    assign sq_push = wr_bd & ~sq_full;
    assign sq_pop  = done_v;
    assign cq_push = done_v & ~cq_full;
    assign cq_pop  = rd_bd & ~cq_empty;

    e1_bd_fifo #(.DEPTH(DEPTH), .WIDTH(MFW+2)) u_sq (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (sq_push),
        .wr_data ({bus_wdata[14:13], bus_wdata[MFW-1:0]}),
        .rd_en   (sq_pop),
        .rd_data (sq_head),
        .full    (sq_full),
        .empty   (sq_empty),
        .level   (sq_level)
    );

    e1_bd_fifo #(.DEPTH(DEPTH), .WIDTH(MFW)) u_cq (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cq_push),
        .wr_data (sq_head[MFW-1:0]),
        .rd_en   (cq_pop),
        .rd_data (cq_head),
        .full    (cq_full),
        .empty   (cq_empty),
        .level   (cq_level)
    );

    always_comb begin
        csr_d      = csr_q;
        irq_en_d   = irq_en_q;
        thr_d      = thr_q;
        ov_d       = ov_q;
        uf_d       = uf_q;
        cnt_d      = cnt_q;
        ctrl_rst_d = ~csr_q[CSR_EN];

        if (wr_csr) begin
            csr_d = bus_wdata[6:0];
        end
        if (wr_irq) begin
            irq_en_d = bus_wdata[2:0];
            thr_d    = bus_wdata[11:8];
        end

        // Clears are applied first so a coincident event overrides them.
        if (wr_csr && bus_wdata[CSR_OV_CLR]) begin
            ov_d = 1'b0;
        end
        if (done_v && cq_full) begin
            ov_d = 1'b1;
        end
        if (wr_csr && bus_wdata[CSR_UF_CLR]) begin
            uf_d  = 1'b0;
            cnt_d = '0;
        end
        if (bd_miss) begin
            uf_d = 1'b1;
            if (cnt_d != '1) begin
                cnt_d = cnt_d + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_q      <= '0;
            ctrl_rst_q <= 1'b1;
            irq_en_q   <= '0;
            thr_q      <= '0;
            ov_q       <= 1'b0;
            uf_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            csr_q      <= csr_d;
            ctrl_rst_q <= ctrl_rst_d;
            irq_en_q   <= irq_en_d;
            thr_q      <= thr_d;
            ov_q       <= ov_d;
            uf_q       <= uf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mode      = mode_e'(csr_q[2:1]);
    assign low_water = (4'(sq_level) <= thr_q);

    always_comb begin
        bus_rdata = '0;
        if (bus_addr_sel) begin
            case (bus_addr_lsb)
                REG_CSR: bus_rdata = {2'b00, ov_q, uf_q, cq_full, cq_empty,
                                      sq_full, sq_empty, 1'b0, csr_q};
                REG_BD: begin
                    bus_rdata[MFW-1:0] = cq_head;
                    bus_rdata[15]      = ~cq_empty;
                end
                REG_IRQ: bus_rdata = {~cq_empty, uf_q, low_water, 1'b0, thr_q,
                                      5'b00000, irq_en_q};
                default: bus_rdata = {8'(cnt_q), 4'(cq_level), 4'(sq_level)};
            endcase
        end
    end

    assign bd_mf           = sq_head[MFW-1:0];
    assign bd_crc_e        = (mode == MODE_CRC4_AUTO) ? crc_e_auto : sq_head[MFW+1:MFW];
    assign bd_valid        = ~sq_empty;
    assign crc_e_ack       = bd_done;
    assign ctrl_rst        = ctrl_rst_q;
    assign ctrl_time_src   = csr_q[CSR_TSRC];
    assign ctrl_alarm      = csr_q[CSR_ALARM];
    assign ctrl_loopback   = csr_q[6:5];
    assign ctrl_do_framing = (mode != MODE_RAW);
    assign ctrl_do_crc4    = mode[1];

    assign irq = (irq_en_q[IRQ_CQ_EN] & ~cq_empty) |
                 (irq_en_q[IRQ_UF_EN] & uf_q) |
                 (irq_en_q[IRQ_LW_EN] & low_water);

    // Write-data bits that no register field uses.
    assign unused_bits = ^{bus_wdata[15], bus_wdata[7]};

endmodule

// File: tb/tb_e1_wb_tx_bdmgr.sv
module tb_e1_wb_tx_bdmgr;
  localparam int MFW = 7;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           bus_addr_sel = 1'b0;
  logic [1:0]     bus_addr_lsb = 2'd0;
  logic [15:0]    bus_wdata = 16'h0;
  logic [15:0]    bus_rdata;
  logic           bus_we = 1'b0;
  logic           bus_clr = 1'b0;
  logic [MFW-1:0] bd_mf;
  logic [1:0]     bd_crc_e;
  logic           bd_valid;
  logic           bd_done = 1'b0;
  logic           bd_miss = 1'b0;
  logic [1:0]     crc_e_auto = 2'b00;
  logic           crc_e_ack;
  logic           ctrl_rst, ctrl_time_src, ctrl_do_framing, ctrl_do_crc4, ctrl_alarm;
  logic [1:0]     ctrl_loopback;
  logic           irq;

  e1_wb_tx_bdmgr #(.MFW(MFW), .DEPTH(DEPTH), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .bus_addr_sel(bus_addr_sel), .bus_addr_lsb(bus_addr_lsb),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_we(bus_we), .bus_clr(bus_clr),
    .bd_mf(bd_mf), .bd_crc_e(bd_crc_e), .bd_valid(bd_valid),
    .bd_done(bd_done), .bd_miss(bd_miss),
    .crc_e_auto(crc_e_auto), .crc_e_ack(crc_e_ack),
    .ctrl_rst(ctrl_rst), .ctrl_time_src(ctrl_time_src),
    .ctrl_do_framing(ctrl_do_framing), .ctrl_do_crc4(ctrl_do_crc4),
    .ctrl_alarm(ctrl_alarm), .ctrl_loopback(ctrl_loopback), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] sq_exp_q[$];   // {E bits, mf} of accepted submit BDs
  logic [6:0] cq_exp_q[$];   // mf expected from completion reads
  int cur_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive at negedge, effect at the following posedge
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_addr_sel = 1'b1; bus_we = 1'b1; bus_addr_lsb = a; bus_wdata = d;
    @(negedge clk);
    bus_addr_sel = 1'b0; bus_we = 1'b0; bus_wdata = 16'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bus_addr_sel = 1'b1; bus_we = 1'b0; bus_addr_lsb = a;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_addr_sel = 1'b0;
  endtask

  task automatic read_check(input logic [1:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic submit(input logic [6:0] mf, input logic [1:0] e);
    bus_write(2'd1, {1'b0, e, 6'b0, mf});
    if (sq_exp_q.size() < DEPTH) sq_exp_q.push_back({e, mf});
  endtask

  task automatic do_done();
    logic [8:0] h;
    @(negedge clk);
    bd_done = 1'b1;
    #1;
    check("crc_e_ack", {31'h0, crc_e_ack}, 32'h1);
    if (sq_exp_q.size() > 0) begin
      h = sq_exp_q.pop_front();
      check("bd_mf", {25'h0, bd_mf}, {25'h0, h[6:0]});
      if (cur_mode != 3) check("bd_crc_e", {30'h0, bd_crc_e}, {30'h0, h[8:7]});
      if (cq_exp_q.size() < DEPTH) cq_exp_q.push_back(h[6:0]);
    end
    @(negedge clk);
    bd_done = 1'b0;
  endtask

  task automatic read_cq();
    logic [15:0] d;
    logic [15:0] exp;
    bus_read(2'd1, d);
    exp = 16'h0;
    if (cq_exp_q.size() > 0) exp = {1'b1, 8'h00, cq_exp_q.pop_front()};
    check("cq_read", {16'h0, d}, {16'h0, exp});
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl_rst", {31'h0, ctrl_rst}, 32'h1);
    check("rst_bd_valid", {31'h0, bd_valid}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rdata_unsel", {16'h0, bus_rdata}, 32'h0);
    check("ctrl_rst_after", {31'h0, ctrl_rst}, 32'h1);
    read_check(2'd0, 16'h0500, "rst_csr");
    read_check(2'd3, 16'h0000, "rst_levels");
    read_check(2'd2, 16'h2000, "rst_irq_reg");

    // enable, mode framed: ctrl_rst falls two edges after the write cycle
    @(negedge clk);
    bus_addr_sel = 1'b1; bus_we = 1'b1; bus_addr_lsb = 2'd0; bus_wdata = 16'h0003;
    @(negedge clk);
    bus_addr_sel = 1'b0; bus_we = 1'b0;
    check("ctrl_rst_edge1", {31'h0, ctrl_rst}, 32'h1);
    @(negedge clk);
    check("ctrl_rst_edge2", {31'h0, ctrl_rst}, 32'h0);
    check("do_framing", {31'h0, ctrl_do_framing}, 32'h1);
    check("do_crc4", {31'h0, ctrl_do_crc4}, 32'h0);
    cur_mode = 1;

    // write with bus_clr is suppressed
    @(negedge clk);
    bus_addr_sel = 1'b1; bus_we = 1'b1; bus_clr = 1'b1; bus_addr_lsb = 2'd0; bus_wdata = 16'h0000;
    @(negedge clk);
    bus_addr_sel = 1'b0; bus_we = 1'b0; bus_clr = 1'b0;
    read_check(2'd0, 16'h0503, "csr_clr_kill");

    // five submits into a 4-deep queue
    for (int i = 0; i < 5; i++) submit(7'(i), 2'(i));
    read_check(2'd3, 16'h0004, "sq_level_full");
    read_check(2'd0, 16'h0603, "csr_sq_full");
    #1;
    check("bd_valid", {31'h0, bd_valid}, 32'h1);
    for (int i = 0; i < 4; i++) do_done();
    read_check(2'd3, 16'h0040, "cq_level_4");
    for (int i = 0; i < 5; i++) read_cq();

    // underflow saturation
    @(negedge clk);
    bd_miss = 1'b1;
    repeat (300) @(negedge clk);
    bd_miss = 1'b0;
    read_check(2'd3, 16'hFF00, "uf_saturated");
    read_check(2'd0, 16'h1503, "csr_uf_flag");
    // clear coincident with a miss: event wins
    @(negedge clk);
    bus_addr_sel = 1'b1; bus_we = 1'b1; bus_addr_lsb = 2'd0; bus_wdata = 16'h1003; bd_miss = 1'b1;
    @(negedge clk);
    bus_addr_sel = 1'b0; bus_we = 1'b0; bd_miss = 1'b0;
    read_check(2'd3, 16'h0100, "uf_clr_and_miss");
    read_check(2'd0, 16'h1503, "csr_uf_still");
    bus_write(2'd0, 16'h1003);
    read_check(2'd3, 16'h0000, "uf_cleared");
    read_check(2'd0, 16'h0503, "csr_uf_cleared");

    // completion overflow
    for (int i = 0; i < 4; i++) submit(7'(10 + i), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 4; i++) do_done();
    submit(7'd14, 2'd0);
    do_done();
    read_check(2'd0, 16'h2903, "csr_overflow");
    read_check(2'd3, 16'h0040, "cq_level_stays");
    bus_write(2'd0, 16'h2003);
    read_check(2'd0, 16'h0903, "csr_ov_cleared");
    for (int i = 0; i < 4; i++) read_cq();

    // low-water interrupt
    bus_write(2'd2, 16'h0104);
    submit(7'd20, 2'b01);
    submit(7'd21, 2'b01);
    #1;
    check("irq_lw_above", {31'h0, irq}, 32'h0);
    do_done();
    check("irq_lw_rise", {31'h0, irq}, 32'h1);
    read_check(2'd2, 16'hA104, "irq_reg");
    bus_write(2'd2, 16'h0100);
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 16'h0001);
    check("irq_cq", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 16'h0000);
    read_cq();

    // auto E bits
    crc_e_auto = 2'b10;
    bus_write(2'd0, 16'h0007);
    cur_mode = 3;
    check("crc_e_auto", {30'h0, bd_crc_e}, 32'h2);
    bus_write(2'd0, 16'h0005);
    cur_mode = 2;
    check("crc_e_head", {30'h0, bd_crc_e}, 32'h1);
    check("crc4_mode2", {31'h0, ctrl_do_crc4}, 32'h1);
    check("framing_mode2", {31'h0, ctrl_do_framing}, 32'h1);

    // reset mid-operation flushes queues
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sq_exp_q.delete();
    cq_exp_q.delete();
    check("mid_rst_valid", {31'h0, bd_valid}, 32'h0);
    check("mid_rst_ctrl_rst", {31'h0, ctrl_rst}, 32'h1);
    read_check(2'd3, 16'h0000, "mid_rst_levels");
    read_check(2'd0, 16'h0500, "mid_rst_csr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
